// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
//   gp_t             : per-node {generate, propagate} pair
//   levels_of        : number of prefix levels for a given width
//   rank_after_level : prefix level that intermediate rank k follows
//   has_rank_after   : whether any intermediate rank follows a given level
package adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int levels_of(input int width);
        return $clog2(width);
    endfunction

    // ceil(k*levels/stages); level 0 is the precompute
    function automatic int rank_after_level(input int k, input int levels, input int stages);
        return (k * levels + stages - 1) / stages;
    endfunction

    function automatic bit has_rank_after(input int lvl, input int levels, input int stages);
        for (int k = 1; k < stages; k++) begin
            if (rank_after_level(k, levels, stages) == lvl) return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/pipelined_prefix_adder_prefix_level.sv
// One combinational Kogge-Stone level: each node at or above DIST combines
// with the node DIST below it; lower nodes already hold their full prefix.
//   gp_in  : {g,p} per node from the previous level
//   gp_out : {g,p} per node after this level
module prefix_level
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  gp_t [WIDTH-1:0] gp_in,
    output gp_t [WIDTH-1:0] gp_out
);

    for (genvar e = 0; e < WIDTH; e++) begin : g_node
        if (e >= DIST) begin : g_comb
            assign gp_out[e].g = gp_in[e].g | (gp_in[e].p & gp_in[e-DIST].g);
            assign gp_out[e].p = gp_in[e].p & gp_in[e-DIST].p;
        end else begin : g_pass
            assign gp_out[e] = gp_in[e];
        end
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// {cout,s} = a + (sub ? ~b : b) + cin; ovf is signed overflow, zero is s==0.
// Latency is STAGES cycles; a single global stall freezes every rank.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result beat handshake (s, cout, ovf, zero)
module pipelined_prefix_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = levels_of(WIDTH);

    // Prefix nodes are shifted up by one: node[0] is cin (generate at bit -1),
    // node[e] is bit e-1. After LEVELS levels node[i] is the carry into bit i.
    // The MSB's own g/p is kept aside to form cout at the end.
    typedef struct packed {
        gp_t [WIDTH-1:0]  node;
        logic [WIDTH-1:0] p;
        logic             g_msb;
        logic             a_msb;
        logic             b_msb;
    } beat_t;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
        logic             zero;
    } res_t;

    logic              advance, accept, load_vld;
    logic [STAGES-1:0] vld_pipe_q, vld_pipe_d, vld_shift;

    assign out_valid = vld_pipe_q[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && advance;

    // bit r is the valid that rank r loads on an advancing edge
    assign vld_shift  = (vld_pipe_q << 1) | STAGES'(accept);
    assign load_vld   = vld_shift[STAGES-1];
    assign vld_pipe_d = advance ? vld_shift : vld_pipe_q;

    // Level 0: bitwise precompute
    logic [WIDTH-1:0] b_eff, p0, g0;
    beat_t            pre_beat;

    always_comb begin
        b_eff = sub ? ~b : b;
        p0    = a ^ b_eff;
        g0    = a & b_eff;
        pre_beat.node[0] = '{g: cin, p: 1'b0};
        for (int e = 1; e < WIDTH; e++) pre_beat.node[e] = '{g: g0[e-1], p: p0[e-1]};
        pre_beat.p     = p0;
        pre_beat.g_msb = g0[WIDTH-1];
        pre_beat.a_msb = a[WIDTH-1];
        pre_beat.b_msb = b_eff[WIDTH-1];
    end

    // Prefix levels with intermediate ranks inserted where placement asks.
    // Intermediate data is unreset; only valid bits and the output rank reset.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        beat_t beat_comb, beat_out;

        if (l == 0) begin : g_pre
            assign beat_comb = pre_beat;
        end else begin : g_kst
            prefix_level #(.WIDTH(WIDTH), .DIST(1 << (l - 1))) u_level (
                .gp_in  (g_lvl[l-1].beat_out.node),
                .gp_out (beat_comb.node)
            );
            assign beat_comb.p     = g_lvl[l-1].beat_out.p;
            assign beat_comb.g_msb = g_lvl[l-1].beat_out.g_msb;
            assign beat_comb.a_msb = g_lvl[l-1].beat_out.a_msb;
            assign beat_comb.b_msb = g_lvl[l-1].beat_out.b_msb;
        end

        if (has_rank_after(l, LEVELS, STAGES)) begin : g_rank
            beat_t beat_d, beat_q;
            always_comb begin
                beat_d = beat_q;
                if (advance) beat_d = beat_comb;
            end
            always_ff @(posedge clk) beat_q <= beat_d;
            assign beat_out = beat_q;
        end else begin : g_thru
            assign beat_out = beat_comb;
        end
    end

    // Sum, carry-out and flags
    beat_t            fin;
    res_t             res;
    logic [WIDTH-1:0] carry;
    logic             unused_node_p;

    assign fin = g_lvl[LEVELS].beat_out;

    always_comb begin
        unused_node_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i]      = fin.node[i].g;
            unused_node_p = unused_node_p ^ fin.node[i].p;
        end
        res.s    = fin.p ^ carry;
        res.cout = fin.g_msb | (fin.p[WIDTH-1] & carry[WIDTH-1]);
        res.ovf  = (fin.a_msb == fin.b_msb) && (res.s[WIDTH-1] != fin.a_msb);
        res.zero = (res.s == '0);
    end

    // Output rank: loads zeros for a bubble so idle outputs read as 0
    res_t out_d, out_q;

    always_comb begin
        out_d = out_q;
        if (advance) out_d = load_vld ? res : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            out_q      <= out_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign s    = out_q.s;
    assign cout = out_q.cout;
    assign ovf  = out_q.ovf;
    assign zero = out_q.zero;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
module tb_pipelined_prefix_adder;

    localparam int W   = 32;
    localparam int S   = 2;
    localparam int NSW = 17;   // 4 + 6 + 7 sweep configurations

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [W-1:0] a, b, s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sweep_done = 0;
    bit mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        logic [31:0] s;
        logic        cout, ovf, zero;
    } vec_t;

    typedef struct {
        logic [34:0] res;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t q[$];

    pipelined_prefix_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic logic [34:0] model32(input logic [31:0] x, y, input logic c, m);
        logic [31:0] ye;
        logic [32:0] t;
        ye = m ? ~y : y;
        t  = {1'b0, x} + {1'b0, ye} + {32'd0, c};
        return {t[31:0], t[32], (x[31] == ye[31]) && (t[31] != x[31]), t[31:0] == 32'd0};
    endfunction

    // Scoreboard monitor for the main instance
    always @(negedge clk) begin
        #1;
        if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("no_stale_output", 80'(out_valid), 80'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 80'({s, cout, ovf, zero}), 80'(e.res));
                if (e.chk_lat) check("latency", 80'(cyc - e.acc), 80'(S));
            end
        end
    end

    task automatic send(input logic [31:0] x, y, input logic c, m, input logic [34:0] r, input bit lat);
        int g;
        @(negedge clk);
        a = x; b = y; cin = c; sub = m; in_valid = 1'b1;
        #1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (!in_ready) check("send_timeout", 80'(in_ready), 80'(1));
        else q.push_back('{res: r, acc: cyc, chk_lat: lat});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Main directed sequence
    initial begin
        vec_t        tbl[8];
        logic [34:0] snap;
        logic [31:0] ra, rb;
        int          g;

        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h12345678, 32'h12345678, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = 32'hDEADBEEF; b = 32'h1; cin = 1'b0; sub = 1'b0;

        // reset held 3 cycles with a beat presented
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", 80'(out_valid), 80'(0));
            check("rst_s", 80'(s), 80'(0));
        end
        reset = 1'b0; in_valid = 1'b0; mon_en = 1'b1;
        #1;
        check("in_ready_after_rst", 80'(in_ready), 80'(1));
        repeat (4) begin
            @(negedge clk);
            #1;
            check("post_rst_idle", 80'(out_valid), 80'(0));
        end

        // back-to-back table vectors with fixed latency
        for (int i = 0; i < 8; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                 {tbl[i].s, tbl[i].cout, tbl[i].ovf, tbl[i].zero}, 1'b1);
        idle(S + 3);
        check("table_drained", 80'(q.size()), 80'(0));

        // backpressure with a full pipeline
        for (int i = 0; i < 2; i++) begin
            ra = $urandom; rb = $urandom;
            send(ra, rb, 1'b0, 1'(i), model32(ra, rb, 1'b0, 1'(i)), 1'b0);
        end
        @(negedge clk);
        ra = $urandom; rb = $urandom;
        a = ra; b = rb; cin = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("bp_out_valid", 80'(out_valid), 80'(1));
        check("bp_in_ready", 80'(in_ready), 80'(0));
        snap = {s, cout, ovf, zero};
        repeat (2) begin
            @(negedge clk);
            #1;
            check("bp_in_ready", 80'(in_ready), 80'(0));
            check("bp_hold", 80'({out_valid, s, cout, ovf, zero}), 80'({1'b1, snap}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_hold_last", 80'({s, cout, ovf, zero}), 80'(snap));
        check("bp_release_in_ready", 80'(in_ready), 80'(1));
        if (in_ready) q.push_back('{res: model32(ra, rb, 1'b1, 1'b0), acc: cyc, chk_lat: 1'b0});
        idle(S + 4);
        check("bp_drained", 80'(q.size()), 80'(0));

        // reset with two beats in flight
        out_ready = 1'b0;
        send(32'h11111111, 32'h22222222, 1'b0, 1'b0, model32(32'h11111111, 32'h22222222, 1'b0, 1'b0), 1'b0);
        send(32'h33333333, 32'h44444444, 1'b0, 1'b0, model32(32'h33333333, 32'h44444444, 1'b0, 1'b0), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_out_valid", 80'(out_valid), 80'(1));
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 80'(out_valid), 80'(0));
        check("mid_rst_s", 80'(s), 80'(0));
        reset = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            check("mid_rst_no_stale", 80'(out_valid), 80'(0));
        end

        g = 0;
        while (sweep_done < NSW && g < 30000) begin
            @(negedge clk);
            g++;
        end
        check("sweep_all_done", 80'(sweep_done), 80'(NSW));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Random sweep: every legal STAGES for WIDTH 8, 32, 64
    for (genvar wi = 0; wi < 3; wi++) begin : g_w
        localparam int SW = (wi == 0) ? 8 : (wi == 1) ? 32 : 64;
        for (genvar st = 1; st <= $clog2(SW) + 1; st++) begin : g_s
            logic          rst, iv, ir, ci, sb, ov, ordy, co, of, zr;
            logic [SW-1:0] sa, sbv, ss;
            logic [SW+2:0] sq[$];

            pipelined_prefix_adder #(.WIDTH(SW), .STAGES(st)) u_dut (
                .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir),
                .a(sa), .b(sbv), .cin(ci), .sub(sb),
                .out_valid(ov), .out_ready(ordy),
                .s(ss), .cout(co), .ovf(of), .zero(zr)
            );

            function automatic logic [SW+2:0] ref_model(input logic [SW-1:0] x, y, input logic c, m);
                logic [SW-1:0] ye;
                logic [SW:0]   t;
                ye = m ? ~y : y;
                t  = {1'b0, x} + {1'b0, ye} + {{SW{1'b0}}, c};
                return {t[SW-1:0], t[SW], (x[SW-1] == ye[SW-1]) && (t[SW-1] != x[SW-1]),
                        t[SW-1:0] == '0};
            endfunction

            function automatic logic [SW-1:0] rnd();
                logic [63:0] r;
                r = {$urandom, $urandom};
                case ($urandom_range(0, 7))
                    0:       return '0;
                    1:       return '1;
                    2:       return {1'b1, {(SW-1){1'b0}}};
                    3:       return {1'b0, {(SW-1){1'b1}}};
                    default: return r[SW-1:0];
                endcase
            endfunction

            initial begin
                logic [SW+2:0] snap;
                bit            stall_prev;
                int            sent, guard;
                string         nm;
                nm = $sformatf("sweep_w%0d_s%0d", SW, st);
                rst = 1'b1; iv = 1'b0; ordy = 1'b0; sa = '0; sbv = '0; ci = 1'b0; sb = 1'b0;
                stall_prev = 0; sent = 0; guard = 0; snap = '0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                while ((sent < 1000 || sq.size() != 0) && guard < 20000) begin
                    @(negedge clk);
                    iv   = (sent < 1000) && ($urandom_range(0, 3) != 0);
                    sa   = rnd();
                    sbv  = rnd();
                    ci   = 1'($urandom_range(0, 1));
                    sb   = 1'($urandom_range(0, 1));
                    ordy = ($urandom_range(0, 3) != 0);
                    #1;
                    if (stall_prev)
                        check({nm, "_hold"}, 80'({ov, ss, co, of, zr}), 80'({1'b1, snap}));
                    if (iv && ir) begin
                        sq.push_back(ref_model(sa, sbv, ci, sb));
                        sent++;
                    end
                    if (ov && ordy) begin
                        if (sq.size() == 0) check({nm, "_stale"}, 80'(ov), 80'(0));
                        else check(nm, 80'({ss, co, of, zr}), 80'(sq.pop_front()));
                    end
                    stall_prev = ov && !ordy;
                    snap       = {ss, co, of, zr};
                    guard++;
                end
                check({nm, "_drained"}, 80'(sq.size()), 80'(0));
                check({nm, "_sent"}, 80'(sent), 80'(1000));
                sweep_done++;
            end
        end
    end

endmodule
